alu_step_ctrl: RTL and testbench
================================

Name: alu_step_ctrl

Overview:
- Button-driven sequencer for the 32-bit board ALU. It replaces the three separate load/execute buttons with a single debounced STEP button that walks through: capture A, capture B, capture opcode, execute, show.
- It holds the operand/opcode registers feeding the combinational ALU and latches the ALU result and flags.
- It sits between the board switches/buttons and the ALU and display logic inside the board top.

Parameters:
- DW, 32, operand/result width
- OPW, 4, opcode width, taken from sw[OPW-1:0]
- DEB_CYCLES, 20000, consecutive stable cycles required to accept a button level (minimum 2)
- SETTLE, 1, cycles to wait in EXEC before sampling the ALU (minimum 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_step  in  1  raw STEP button, asynchronous, may bounce
- btn_clr  in  1  raw CLEAR button, asynchronous, may bounce
- sw  in  DW  data switches
- alu_f_in  in  DW  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_flags_in  in  4  ALU flags {ZF,SF,OF,CF}
- alu_a  out  DW  operand A register
- alu_b  out  DW  operand B register
- alu_op  out  OPW  opcode register
- result  out  DW  latched ALU result
- flags  out  4  latched {ZF,SF,OF,CF}, drives led
- state  out  3  current FSM state code
- disp_data  out  DW  value for the seven-segment display
- done  out  1  high while in S_DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers, result, flags and done go to 0; state goes to S_A.
  - Debouncer synchronisers and counters clear.
  - Reset is legal in any state, including mid-EXEC; no partial capture survives it.
- Button conditioning, per button:
  - 2-FF synchroniser, then a counter.
  - The debounced level changes only after DEB_CYCLES consecutive cycles of the new synchronised level.
  - A rising edge of the debounced level gives a 1-cycle pulse (step_p, clr_p).
  - Holding a button yields exactly one pulse. Glitches shorter than DEB_CYCLES yield none.
  - Latency from a stable raw edge to the pulse is DEB_CYCLES+2 or DEB_CYCLES+3 cycles.
- State codes: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_DONE=4.
- FSM transitions, with register updates on the same edge:
  - S_A: on step_p, alu_a<=sw, go to S_B.
  - S_B: on step_p, alu_b<=sw, go to S_OP.
  - S_OP: on step_p, alu_op<=sw[OPW-1:0], load the settle counter to SETTLE, go to S_EXEC.
  - S_EXEC: count down while ignoring step_p. When the count reaches 0: result<=alu_f_in, flags<=alu_flags_in, go to S_DONE.
    - With SETTLE=1, result is valid 2 cycles after the S_OP step_p edge.
  - S_DONE: done=1. On step_p, go to S_A. alu_a, alu_b, alu_op, result and flags are held until overwritten.
- clr_p, in any state: alu_a, alu_b, alu_op, result and flags go to 0, state goes to S_A, done goes to 0.
  - clr_p has priority over step_p in the same cycle.
- disp_data (registered, 1 cycle behind state/sw):
  - S_A, S_B, S_OP: shows live sw.
  - S_EXEC: shows alu_a.
  - S_DONE: shows result.
- No arithmetic is done here; ALU encodings are opaque. sw[DW-1:OPW] is ignored in S_OP.

Optional Feature:
- Macro: ALU_STEP_CHAIN_EN.
- Defined: in S_DONE, step_p loads alu_a<=result and goes directly to S_B (accumulator chaining). clr_p still returns to S_A.
- Undefined: S_DONE returns to S_A as specified above.

Decomposition:
- Shared package alu_step_pkg holds:
  - the state enum/localparams S_A..S_DONE;
  - the flag bit indices ZF=3, SF=2, OF=1, CF=0;
  - the DW/OPW defaults.
- One sub-module, btn_debounce (synchroniser, counter, edge pulse; parameter DEB_CYCLES), instantiated twice.

Test Plan:
Use DEB_CYCLES=4, SETTLE=1, and a behavioural ALU model (op 0 = add, op 1 = sub).
1. Bounce rejection: btn_step toggles with 2-cycle pulses for 20 cycles, then is held high 10 cycles -> exactly one step_p; state 0->1.
2. Add sequence: sw=5 then step, sw=3 then step, sw=0 then step -> alu_a=5, alu_b=3, alu_op=0; result=8, flags=0000 two cycles after the third pulse; done=1; disp_data=8.
3. Subtract: A=3, B=5, op=1 -> result=FFFFFFFE, flags=0101 (SF, CF set); state=4.
4. Clear priority: btn_clr and btn_step pressed together in S_B -> state=0; alu_a, alu_b, result all 0.
5. Async reset mid-EXEC: drop rst_n in S_EXEC -> all outputs 0 immediately without a clock edge; after release the next step captures A.
6. With ALU_STEP_CHAIN_EN: after 5+3=8, sw=2 then step -> state=S_B, alu_a=8; B=2, op=0 -> result=10 (0x0000000A).

Source files
------------

// File: rtl/alu_step_pkg.sv
// Shared definitions for the single-button ALU step sequencer.
// Holds the FSM state codes, the flag bit positions and the default widths.
package alu_step_pkg;

   localparam int DW_DEF  = 32;
   localparam int OPW_DEF = 4;

   // Flag bit positions inside the 4-bit {ZF,SF,OF,CF} vector
   localparam int ZF = 3;
   localparam int SF = 2;
   localparam int OF = 1;
   localparam int CF = 0;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_OP   = 3'd2,
      S_EXEC = 3'd3,
      S_DONE = 3'd4
   } state_e;

endpackage

// File: rtl/alu_step_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each rising edge of the debounced level.
module btn_debounce #(
   parameter int DEB_CYCLES = 20000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   logic          sync1_q, sync2_q;
   logic          level_q, levelPrev_q;
   logic [CW-1:0] cnt_q;

   // The level flips only after DEB_CYCLES consecutive samples disagree with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         levelPrev_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync1_q     <= btn_i;
         sync2_q     <= sync1_q;
         levelPrev_q <= level_q;
         if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
               level_q <= sync2_q;
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign pulse_o = level_q & ~levelPrev_q;

endmodule

// File: rtl/alu_step_ctrl.sv
// Single STEP-button sequencer feeding the board ALU: capture A, B, opcode,
// execute, show. Define ALU_STEP_CHAIN_EN to chain the result back into A.
module alu_step_ctrl
   import alu_step_pkg::*;
#(
   parameter int DW         = DW_DEF,
   parameter int OPW        = OPW_DEF,
   parameter int DEB_CYCLES = 20000,
   parameter int SETTLE     = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           btn_step,
   input  logic           btn_clr,
   input  logic [DW-1:0]  sw,
   input  logic [DW-1:0]  alu_f_in,
   input  logic [3:0]     alu_flags_in,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [OPW-1:0] alu_op,
   output logic [DW-1:0]  result,
   output logic [3:0]     flags,
   output logic [2:0]     state,
   output logic [DW-1:0]  disp_data,
   output logic           done
);

   localparam int SCW = $clog2(SETTLE + 1);

   logic           step_p, clr_p;
   state_e         state_q, state_d;
   logic [DW-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
   logic [OPW-1:0] op_q, op_d;
   logic [3:0]     flags_q, flags_d;
   logic [SCW-1:0] settle_q, settle_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_step),
      .pulse_o (step_p)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (btn_clr),
      .pulse_o (clr_p)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         res_q    <= '0;
         flags_q  <= '0;
         settle_q <= '0;
         disp_q   <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         res_q    <= res_d;
         flags_q  <= flags_d;
         settle_q <= settle_d;
         disp_q   <= disp_d;
      end
   end

   // CLEAR wins over STEP; EXEC ignores STEP until the ALU has settled
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      res_d    = res_q;
      flags_d  = flags_q;
      settle_d = settle_q;
      if (clr_p) begin
         state_d  = S_A;
         a_d      = '0;
         b_d      = '0;
         op_d     = '0;
         res_d    = '0;
         flags_d  = '0;
         settle_d = '0;
      end else begin
         case (state_q)
            S_A: if (step_p) begin
               a_d     = sw;
               state_d = S_B;
            end
            S_B: if (step_p) begin
               b_d     = sw;
               state_d = S_OP;
            end
            S_OP: if (step_p) begin
               op_d     = sw[OPW-1:0];
               settle_d = SCW'(SETTLE);
               state_d  = S_EXEC;
            end
            S_EXEC: begin
               if (settle_q == '0) begin
                  res_d   = alu_f_in;
                  flags_d = alu_flags_in;
                  state_d = S_DONE;
               end else begin
                  settle_d = settle_q - 1'b1;
               end
            end
            S_DONE: if (step_p) begin
`ifdef ALU_STEP_CHAIN_EN
               a_d     = res_q;
               state_d = S_B;
`else
               state_d = S_A;
`endif
            end
            default: state_d = S_A;
         endcase
      end
   end

   always_comb begin
      disp_d = sw;
      case (state_q)
         S_EXEC:  disp_d = a_q;
         S_DONE:  disp_d = res_q;
         default: disp_d = sw;
      endcase
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_op    = op_q;
   assign result    = res_q;
   assign flags     = flags_q;
   assign state     = state_q;
   assign disp_data = disp_q;
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_step_ctrl.sv
// Self-checking bench for alu_step_ctrl with a behavioural ALU and a
// transaction-level model of the step sequence.
module tb_alu_step_ctrl;

   localparam int DW  = 32;
   localparam int OPW = 4;
   localparam int DEB = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           btnStep, btnClr;
   logic [DW-1:0]  sw;
   logic [DW-1:0]  aluF;
   logic [3:0]     aluFlags;
   logic [DW-1:0]  aluA, aluB, result, dispData;
   logic [OPW-1:0] aluOp;
   logic [3:0]     flags;
   logic [2:0]     state;
   logic           done;

   int checks = 0;
   int errors = 0;

   int             mState;
   logic [DW-1:0]  mA, mB, mRes;
   logic [OPW-1:0] mOp;
   logic [3:0]     mFlags;

   alu_step_ctrl #(.DW(DW), .OPW(OPW), .DEB_CYCLES(DEB), .SETTLE(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_step     (btnStep),
      .btn_clr      (btnClr),
      .sw           (sw),
      .alu_f_in     (aluF),
      .alu_flags_in (aluFlags),
      .alu_a        (aluA),
      .alu_b        (aluB),
      .alu_op       (aluOp),
      .result       (result),
      .flags        (flags),
      .state        (state),
      .disp_data    (dispData),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Board ALU stand-in: returns {ZF,SF,OF,CF,f}; CF is carry on add, borrow on sub
   function automatic logic [35:0] aluModel(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
      logic [32:0] wide;
      logic [31:0] f;
      logic        of, cf;
      wide = '0;
      f    = a;
      of   = 1'b0;
      cf   = 1'b0;
      case (op)
         4'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            f    = wide[31:0];
            cf   = wide[32];
            of   = (a[31] == b[31]) && (f[31] != a[31]);
         end
         4'd1: begin
            f  = a - b;
            cf = (a < b);
            of = (a[31] != b[31]) && (f[31] != a[31]);
         end
         4'd2:    f = a & b;
         4'd3:    f = a | b;
         4'd4:    f = a ^ b;
         default: f = a;
      endcase
      return {(f == 32'd0), f[31], of, cf, f};
   endfunction

   always_comb {aluFlags, aluF} = aluModel(aluA, aluB, aluOp);

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      logic [31:0] expDisp;
      expDisp = (mState == 4) ? mRes : (mState == 3) ? mA : sw;
      checkOutput({tag, ".state"}, {29'd0, state}, mState);
      checkOutput({tag, ".a"}, aluA, mA);
      checkOutput({tag, ".b"}, aluB, mB);
      checkOutput({tag, ".op"}, {28'd0, aluOp}, {28'd0, mOp});
      checkOutput({tag, ".result"}, result, mRes);
      checkOutput({tag, ".flags"}, {28'd0, flags}, {28'd0, mFlags});
      checkOutput({tag, ".done"}, {31'd0, done}, (mState == 4) ? 32'd1 : 32'd0);
      checkOutput({tag, ".disp"}, dispData, expDisp);
   endtask

   task automatic modelReset();
      mState = 0;
      mA = '0; mB = '0; mRes = '0; mOp = '0; mFlags = '0;
   endtask

   task automatic modelStep();
      case (mState)
         0: begin mA = sw; mState = 1; end
         1: begin mB = sw; mState = 2; end
         2: begin
            mOp = sw[OPW-1:0];
            {mFlags, mRes} = aluModel(mA, mB, mOp);
            mState = 4;
         end
         default: begin
`ifdef ALU_STEP_CHAIN_EN
            mA = mRes;
            mState = 1;
`else
            mState = 0;
`endif
         end
      endcase
   endtask

   // Clean press and release, long enough for debounce and EXEC to finish
   task automatic applyStimulus(input bit s, input bit c, input logic [31:0] newSw);
      @(negedge clk);
      sw      = newSw;
      btnStep = s;
      btnClr  = c;
      repeat (DEB + 6) @(negedge clk);
      btnStep = 1'b0;
      btnClr  = 1'b0;
      repeat (DEB + 6) @(negedge clk);
      if (c) modelReset();
      else if (s) modelStep();
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; btnStep = 1'b0; btnClr = 1'b0; sw = '0;
      modelReset();
      repeat (3) @(negedge clk);
      checkAll("reset");
      rst_n = 1'b1;

      // Bounce rejection: 2-cycle glitches, then a clean hold
      sw = 32'h11;
      for (int i = 0; i < 5; i++) begin
         btnStep = 1'b1; repeat (2) @(negedge clk);
         btnStep = 1'b0; repeat (2) @(negedge clk);
      end
      repeat (DEB + 4) @(negedge clk);
      checkOutput("bounceNoStep", {29'd0, state}, 32'd0);
      btnStep = 1'b1; repeat (10) @(negedge clk);
      btnStep = 1'b0; repeat (DEB + 6) @(negedge clk);
      modelStep();
      checkOutput("holdOneStep", {29'd0, state}, 32'd1);
      checkAll("bounce");
      applyStimulus(0, 1, 32'h0);

      // Add 5 + 3
      applyStimulus(1, 0, 32'd5);
      applyStimulus(1, 0, 32'd3);
      applyStimulus(1, 0, 32'd0);
      checkOutput("addResult", result, 32'd8);
      checkOutput("addFlags", {28'd0, flags}, 32'd0);
      checkOutput("addDone", {31'd0, done}, 32'd1);
      checkOutput("addDisp", dispData, 32'd8);
      checkAll("add");

      // Subtract 3 - 5
      applyStimulus(0, 1, 32'h0);
      applyStimulus(1, 0, 32'd3);
      applyStimulus(1, 0, 32'd5);
      applyStimulus(1, 0, 32'd1);
      checkOutput("subResult", result, 32'hFFFF_FFFE);
      checkOutput("subFlags", {28'd0, flags}, 32'b0101);
      checkOutput("subState", {29'd0, state}, 32'd4);
      checkAll("sub");

      // Clear and step together in S_B
      applyStimulus(0, 1, 32'h0);
      applyStimulus(1, 0, 32'd7);
      checkOutput("inStateB", {29'd0, state}, 32'd1);
      applyStimulus(1, 1, 32'd9);
      checkOutput("clrState", {29'd0, state}, 32'd0);
      checkOutput("clrA", aluA, 32'd0);
      checkOutput("clrB", aluB, 32'd0);
      checkOutput("clrResult", result, 32'd0);
      checkAll("clrPrio");

      // Accumulator chaining (or plain return to S_A when disabled)
      applyStimulus(1, 0, 32'd5);
      applyStimulus(1, 0, 32'd3);
      applyStimulus(1, 0, 32'd0);
      applyStimulus(1, 0, 32'd2);
      checkAll("afterDone");
`ifdef ALU_STEP_CHAIN_EN
      checkOutput("chainState", {29'd0, state}, 32'd1);
      checkOutput("chainA", aluA, 32'd8);
      applyStimulus(1, 0, 32'd2);
      applyStimulus(1, 0, 32'd0);
      checkOutput("chainResult", result, 32'h0000_000A);
      checkAll("chain");
`endif
      applyStimulus(0, 1, 32'h0);

      // Async reset while in S_EXEC
      applyStimulus(1, 0, 32'd100);
      applyStimulus(1, 0, 32'd23);
      @(negedge clk);
      sw = 32'd0;
      btnStep = 1'b1;
      found = 1'b0;
      for (int i = 0; i < DEB + 12 && !found; i++) begin
         @(negedge clk);
         if (state == 3'd3) found = 1'b1;
      end
      checkOutput("execReached", {31'd0, found}, 32'd1);
      rst_n = 1'b0;
      #1;
      btnStep = 1'b0;
      modelReset();
      checkOutput("rstState", {29'd0, state}, 32'd0);
      checkOutput("rstA", aluA, 32'd0);
      checkOutput("rstB", aluB, 32'd0);
      checkOutput("rstResult", result, 32'd0);
      checkOutput("rstDone", {31'd0, done}, 32'd0);
      checkOutput("rstDisp", dispData, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1, 0, 32'h1234_5678);
      checkOutput("postRstA", aluA, 32'h1234_5678);
      checkAll("postRst");

      // Randomized sequence against the model
      for (int i = 0; i < 30; i++) begin
         int r;
         logic [31:0] v;
         r = $urandom_range(0, 9);
         v = (mState == 2) ? 32'($urandom_range(0, 5)) : $urandom;
         if (r == 0)      applyStimulus(0, 1, v);
         else if (r == 1) applyStimulus(1, 1, v);
         else             applyStimulus(1, 0, v);
         checkAll($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
